// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type issue block: opcode and funct encodings,
// FSM state type and the legality decoder.
package rtype_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    // {funct7, funct3} encodings of the ten supported R-type operations
    localparam logic [9:0] FN_ADD  = {7'b0000000, 3'b000};
    localparam logic [9:0] FN_SUB  = {7'b0100000, 3'b000};
    localparam logic [9:0] FN_SLL  = {7'b0000000, 3'b001};
    localparam logic [9:0] FN_SLT  = {7'b0000000, 3'b010};
    localparam logic [9:0] FN_SLTU = {7'b0000000, 3'b011};
    localparam logic [9:0] FN_XOR  = {7'b0000000, 3'b100};
    localparam logic [9:0] FN_SRL  = {7'b0000000, 3'b101};
    localparam logic [9:0] FN_SRA  = {7'b0100000, 3'b101};
    localparam logic [9:0] FN_OR   = {7'b0000000, 3'b110};
    localparam logic [9:0] FN_AND  = {7'b0000000, 3'b111};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    function automatic logic rtype_legal(input logic [31:0] ins);
        logic [9:0] fn;
        logic       ok;
        fn = {ins[31:25], ins[14:12]};
        ok = 1'b0;
        if (ins[6:0] == OPC_RTYPE) begin
            case (fn)
                FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU,
                FN_XOR, FN_SRL, FN_SRA, FN_OR, FN_AND: ok = 1'b1;
                default:                               ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/rtype_issue_if.sv
// Fetch/preload/retire handshake bundle between the issue block and its host.
interface rtype_issue_if;

    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic        illegal;

    modport master (
        output instr_valid, instr, ld_valid, ld_addr, ld_data,
        input  instr_ready, retire_valid, retire_rd, retire_data, illegal
    );

    modport slave (
        input  instr_valid, instr, ld_valid, ld_addr, ld_data,
        output instr_ready, retire_valid, retire_rd, retire_data, illegal
    );

endinterface

// File: rtl/rtype_regfile.sv
// 32-entry register file: two capture read ports, one combinational debug port,
// one write port shared by preload and writeback, x0 reads as zero.
module rtype_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              ld_we,
    input  logic [4:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic [DATA_W-1:0] regs [32];
    logic              we;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;

    function automatic logic [DATA_W-1:0] rd_reg(input logic [4:0] a);
        return (a == 5'd0) ? '0 : regs[a];
    endfunction

    // Preload and writeback never coincide in the FSM; writeback wins regardless.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (wb_we) begin
            we    = 1'b1;
            waddr = wb_addr;
            wdata = wb_data;
        end else if (ld_we) begin
            we    = 1'b1;
            waddr = ld_addr;
            wdata = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            rs1_data <= '0;
            rs2_data <= '0;
        end else begin
            if (we && (waddr != 5'd0)) begin
                regs[waddr] <= wdata;
            end
            if (rd_en) begin
                rs1_data <= rd_reg(rs1_addr);
                rs2_data <= rd_reg(rs2_addr);
            end
        end
    end

    assign dbg_rdata = rd_reg(dbg_raddr);

endmodule

// File: rtl/rtype_issue.sv
// Single-issue R-type sequencer: fetch, decode, drive an external ALU,
// capture its result and write it back, one instruction every four cycles.
module rtype_issue
    import rtype_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    rtype_issue_if.slave bus,
    output logic [6:0]   alu_opcode,
    output logic [2:0]   alu_funct3,
    output logic [6:0]   alu_funct7,
    output logic [31:0]  alu_in1,
    output logic [31:0]  alu_in2,
    input  logic [31:0]  alu_out,
    input  logic [4:0]   dbg_raddr,
    output logic [31:0]  dbg_rdata
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] instr_q;
    logic        accept;
    logic        legal;
    logic        issue_go;
    logic        ld_we;
    logic        retire_valid_q;
    logic [4:0]  retire_rd_q;
    logic [31:0] retire_data_q;

    assign accept   = (state_q == S_IDLE) && bus.instr_valid;
    assign legal    = rtype_legal(instr_q);
    assign issue_go = (state_q == S_DECODE) && legal;
    assign ld_we    = (state_q == S_IDLE) && bus.ld_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_DECODE;
            S_DECODE: state_d = legal ? S_EXEC : S_IDLE;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch: hold the instruction word for the rest of its flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            instr_q <= bus.instr;
        end
    end

    // Decode -> execute: function fields latched alongside the operand capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opcode <= '0;
            alu_funct3 <= '0;
            alu_funct7 <= '0;
        end else if (issue_go) begin
            alu_opcode <= instr_q[6:0];
            alu_funct3 <= instr_q[14:12];
            alu_funct7 <= instr_q[31:25];
        end
    end

    // Execute -> writeback: result register doubles as the retire payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_valid_q <= 1'b0;
            retire_rd_q    <= '0;
            retire_data_q  <= '0;
        end else begin
            retire_valid_q <= (state_q == S_EXEC);
            if (state_q == S_EXEC) begin
                retire_rd_q   <= instr_q[11:7];
                retire_data_q <= alu_out;
            end
        end
    end

    rtype_regfile #(
        .DATA_W (32)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (issue_go),
        .rs1_addr  (instr_q[19:15]),
        .rs2_addr  (instr_q[24:20]),
        .rs1_data  (alu_in1),
        .rs2_data  (alu_in2),
        .ld_we     (ld_we),
        .ld_addr   (bus.ld_addr),
        .ld_data   (bus.ld_data),
        .wb_we     (retire_valid_q),
        .wb_addr   (retire_rd_q),
        .wb_data   (retire_data_q),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    assign bus.instr_ready  = (state_q == S_IDLE);
    assign bus.illegal      = (state_q == S_DECODE) && !legal;
    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_rd    = retire_rd_q;
    assign bus.retire_data  = retire_data_q;

endmodule

// File: tb/tb_rtype_issue.sv
// Randomized scoreboard bench for rtype_issue with a behavioural ALU and
// a register-array reference model.
module tb_rtype_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;
    logic [4:0]  dbg_raddr = '0;
    logic [31:0] dbg_rdata;

    rtype_issue_if bus();

    rtype_issue dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_out    (alu_out),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          ill;
        logic [4:0]  rd;
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    logic [31:0] mreg [32];
    logic [9:0]  fns [10] = '{10'h000, 10'h100, 10'h001, 10'h002, 10'h003,
                              10'h004, 10'h005, 10'h105, 10'h006, 10'h007};
    int npass = 0;
    int ntot  = 0;

    function automatic logic [31:0] ref_alu(input logic [9:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
        case (fn)
            10'h000: return a + b;
            10'h100: return a - b;
            10'h001: return a << b[4:0];
            10'h002: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            10'h003: return (a < b) ? 32'd1 : 32'd0;
            10'h004: return a ^ b;
            10'h005: return a >> b[4:0];
            10'h105: return 32'($signed(a) >>> b[4:0]);
            10'h006: return a | b;
            10'h007: return a & b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [31:0] w);
        bit ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (fns[i] == {w[31:25], w[14:12]}) ok = 1;
        end
        return ok && (w[6:0] == 7'h33);
    endfunction

    // External ALU; a recognisable junk value whenever the opcode is not R-type.
    always_comb begin
        alu_out = 32'hDEADBEEF;
        if (alu_opcode == 7'h33) alu_out = ref_alu({alu_funct7, alu_funct3}, alu_in1, alu_in2);
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    always @(negedge clk) begin
        if (!rst && (bus.retire_valid || bus.illegal)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {30'b0, bus.retire_valid, bus.illegal}, 32'h0);
            end else begin
                me = q.pop_front();
                chk("out_kind", {30'b0, bus.retire_valid, bus.illegal}, me.ill ? 32'h1 : 32'h2);
                chk("out_latency", 32'(cyc - me.acc), me.ill ? 32'd1 : 32'd3);
                if (!me.ill) begin
                    chk("retire_rd", {27'b0, bus.retire_rd}, {27'b0, me.rd});
                    chk("retire_data", bus.retire_data, me.data);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) chk("ready_timeout", 32'h0, 32'h1);
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        wait_ready();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        if (a != 5'd0) mreg[a] = d;
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] w, input bit cold, input logic [4:0] la,
                         input logic [31:0] ldv, input bit bogus, input bit track);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        wait_ready();
        if (cold) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = la;
            bus.ld_data  = ldv;
            if (la != 5'd0) mreg[la] = ldv;
        end
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        a      = mreg[w[19:15]];
        b      = mreg[w[24:20]];
        e.ill  = !ref_legal(w);
        e.rd   = w[11:7];
        e.data = ref_alu({w[31:25], w[14:12]}, a, b);
        e.acc  = cyc;
        if (track) begin
            q.push_back(e);
            if (!e.ill && e.rd != 5'd0) mreg[e.rd] = e.data;
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.ld_valid    = 1'b0;
        if (bogus) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 5'($urandom_range(1, 31));
            bus.ld_data  = $urandom;
        end
        @(negedge clk);
        bus.ld_valid = 1'b0;
        if (!e.ill) begin
            chk("exec_opcode", {25'b0, alu_opcode}, 32'h33);
            chk("exec_funct3", {29'b0, alu_funct3}, {29'b0, w[14:12]});
            chk("exec_funct7", {25'b0, alu_funct7}, {25'b0, w[31:25]});
            chk("exec_in1", alu_in1, a);
            chk("exec_in2", alu_in2, b);
        end
    endtask

    task automatic dbg_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
        dbg_raddr = a;
        #1;
        chk(nm, dbg_rdata, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [9:0]  fn;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        for (int i = 0; i < 32; i++) mreg[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, bus.instr_ready}, 32'h1);
        chk("rst_retire_valid", {31'b0, bus.retire_valid}, 32'h0);
        chk("rst_retire_data", bus.retire_data, 32'h0);
        chk("rst_illegal", {31'b0, bus.illegal}, 32'h0);
        chk("rst_alu_in1", alu_in1, 32'h0);
        chk("rst_alu_opcode", {25'b0, alu_opcode}, 32'h0);
        rst = 1'b0;

        load(5'd1, 32'd5);
        load(5'd2, 32'd7);
        issue(32'h002081B3, 0, 0, 0, 0, 1);
        wait_ready();
        dbg_chk("add_x3", 5'd3, 32'd12);

        issue(32'h40208233, 0, 0, 0, 1, 1);
        chk("sub_funct7", {25'b0, alu_funct7}, 32'h20);
        wait_ready();
        dbg_chk("sub_x4", 5'd4, 32'hFFFFFFFE);

        load(5'd1, 32'h80000000);
        load(5'd2, 32'd4);
        issue(32'h4020D2B3, 0, 0, 0, 0, 1);
        wait_ready();
        dbg_chk("sra_x5", 5'd5, 32'hF8000000);

        load(5'd1, 32'd5);
        load(5'd2, 32'd7);
        issue(32'h00208033, 0, 0, 0, 0, 1);
        wait_ready();
        dbg_chk("add_x0", 5'd0, 32'h0);

        issue(32'h00100093, 0, 0, 0, 0, 1);
        issue(32'h022081B3, 0, 0, 0, 0, 1);
        wait_ready();
        dbg_chk("ill_x1", 5'd1, 32'd5);
        dbg_chk("ill_x3", 5'd3, 32'd12);

        // Preload in the accept cycle must be seen by the same instruction.
        issue(32'h00208333, 1, 5'd1, 32'd100, 0, 1);
        wait_ready();
        dbg_chk("cold_x6", 5'd6, 32'd107);

        // Abort during EXEC.
        issue(32'h002081B3, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        chk("abort_ready", {31'b0, bus.instr_ready}, 32'h1);
        @(negedge clk);
        chk("abort_ready2", {31'b0, bus.instr_ready}, 32'h1);
        chk("abort_no_retire", {31'b0, bus.retire_valid}, 32'h0);
        dbg_chk("abort_x3", 5'd3, 32'h0);

        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                load(5'($urandom_range(0, 7)), $urandom);
            end
            if ($urandom_range(0, 4) == 0) begin
                w = $urandom;
                if ($urandom_range(0, 1) == 0) w[6:0] = 7'h33;
            end else begin
                fn = fns[$urandom_range(0, 9)];
                w  = {fn[9:3], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      fn[2:0], 5'($urandom_range(0, 7)), 7'h33};
            end
            issue(w, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 2) == 0), 1);
        end

        wait_ready();
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        for (int i = 0; i < 32; i++) begin
            dbg_chk("final_reg", 5'(i), mreg[i]);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
